// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the loopback/command logic and the UART transmit serializer.
interface uart_tx_serializer_if;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_byte, output tx_valid, input tx_ready);
    modport slave  (input tx_byte, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_BITS data bits LSB first,
// optional parity, STOP_BITS stop bits, each held CLKS_PER_BIT clocks.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    uart_tx_serializer_if.slave  tx_if,
    output logic                 serial_tx,
    output logic                 busy
);

    localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_PRE   = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]      IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [7:0]      DATA_MASK = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic            stop_idx;
    logic [7:0]      shreg;
    logic            par_bit;
    logic            ready_q;

    logic [7:0]      data_in;
    logic            load_par;
    logic            xfer;

    assign data_in  = tx_if.tx_byte & DATA_MASK;
    assign load_par = (PARITY == 1) ? ~(^data_in) : (^data_in);
    assign xfer     = tx_if.tx_valid && ready_q;

    assign tx_if.tx_ready = ready_q;

    // Frame sequencer: all outputs are registered, counters only advance inside their state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            ready_q   <= 1'b0;
            serial_tx <= 1'b1;
            busy      <= 1'b0;
        end else if (xfer) begin
            // ready_q is only high in IDLE or the final stop cycle, so a transfer
            // pre-empts both and starts the next frame with no idle gap.
            state     <= ST_START;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= data_in;
            par_bit   <= load_par;
            ready_q   <= 1'b0;
            serial_tx <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    serial_tx <= 1'b1;
                    ready_q   <= 1'b1;
                    busy      <= 1'b0;
                end
                ST_START: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        bit_idx   <= '0;
                        state     <= ST_DATA;
                        serial_tx <= shreg[0];
                        shreg     <= shreg >> 1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                state     <= ST_PARITY;
                                serial_tx <= par_bit;
                            end else begin
                                state     <= ST_STOP;
                                serial_tx <= 1'b1;
                                stop_idx  <= 1'b0;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            serial_tx <= shreg[0];
                            shreg     <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        state     <= ST_STOP;
                        serial_tx <= 1'b1;
                        stop_idx  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    // Open the handshake one cycle early so ready is visible in the last stop cycle.
                    if (cnt == CNT_PRE && stop_idx == STOP_LAST) begin
                        ready_q <= 1'b1;
                    end
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (stop_idx != STOP_LAST) begin
                            stop_idx <= 1'b1;
                        end else begin
                            stop_idx <= 1'b0;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    serial_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: four parameterisations share one
// clock/reset; each has a line-level reference model (a queue of expected
// per-cycle serial levels) compared every cycle, plus directed frame checks.
module tb_uart_tx_serializer;

    localparam int CPB_T  [4] = '{4, 4, 4, 2};
    localparam int DB_T   [4] = '{8, 8, 7, 5};
    localparam int PAR_T  [4] = '{0, 2, 0, 1};
    localparam int SB_T   [4] = '{1, 1, 2, 1};

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] stim_byte  [4];
    logic       stim_valid [4];

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic tr_ser  [4][48];
    logic tr_busy [4][48];
    logic tr_rdy  [4][48];

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int CPB = CPB_T[g];
        localparam int DB  = DB_T[g];
        localparam int PAR = PAR_T[g];
        localparam int SB  = SB_T[g];

        uart_tx_serializer_if u_if ();
        logic serial_tx;
        logic busy;

        assign u_if.tx_byte  = stim_byte[g];
        assign u_if.tx_valid = stim_valid[g];

        uart_tx_serializer #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS   (DB),
            .PARITY      (PAR),
            .STOP_BITS   (SB)
        ) u_dut (
            .clock    (clock),
            .reset_n  (reset_n),
            .tx_if    (u_if),
            .serial_tx(serial_tx),
            .busy     (busy)
        );

        // Expected line level for the current cycle and onward; empty means idle.
        bit line_q[$];
        bit armed = 1'b0;

        initial forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                line_q.delete();
                armed = 1'b0;
            end else begin
                bit         take;
                logic [7:0] d;
                bit         p;
                take = armed && (line_q.size() <= 1) && (stim_valid[g] === 1'b1);
                if (line_q.size() != 0) void'(line_q.pop_front());
                if (take) begin
                    d = stim_byte[g];
                    p = 1'b0;
                    repeat (CPB) line_q.push_back(1'b0);
                    for (int i = 0; i < DB; i++) begin
                        p = p ^ d[i];
                        repeat (CPB) line_q.push_back(d[i]);
                    end
                    if (PAR != 0) repeat (CPB) line_q.push_back((PAR == 2) ? p : ~p);
                    repeat (SB * CPB) line_q.push_back(1'b1);
                end
                armed = 1'b1;
            end
        end

        initial forever begin
            @(negedge clock);
            check_val($sformatf("u%0d.serial_tx", g), serial_tx,
                      (line_q.size() != 0) ? line_q[0] : 1'b1);
            check_val($sformatf("u%0d.busy", g), busy, line_q.size() != 0);
            check_val($sformatf("u%0d.tx_ready", g), u_if.tx_ready,
                      armed && (line_q.size() <= 1));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_valid(input logic v);
        for (int unsigned i = 0; i < 4; i++) stim_valid[i] = v;
    endtask

    task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        stim_byte[0] = b0;
        stim_byte[1] = b1;
        stim_byte[2] = b2;
        stim_byte[3] = b3;
    endtask

    // Called one sample after a transfer edge; records 48 cycles and checks u0's 8N1 frame.
    task automatic capture(input logic [7:0] b0);
        logic [9:0]  seq;
        logic [9:0]  want;
        int unsigned rdy_low;
        int unsigned bsy;
        for (int unsigned i = 0; i < 48; i++) begin
            tr_ser[0][i]  = g_dut[0].serial_tx;
            tr_ser[1][i]  = g_dut[1].serial_tx;
            tr_ser[2][i]  = g_dut[2].serial_tx;
            tr_ser[3][i]  = g_dut[3].serial_tx;
            tr_busy[0][i] = g_dut[0].busy;
            tr_busy[1][i] = g_dut[1].busy;
            tr_busy[2][i] = g_dut[2].busy;
            tr_busy[3][i] = g_dut[3].busy;
            tr_rdy[0][i]  = g_dut[0].u_if.tx_ready;
            tr_rdy[1][i]  = g_dut[1].u_if.tx_ready;
            tr_rdy[2][i]  = g_dut[2].u_if.tx_ready;
            tr_rdy[3][i]  = g_dut[3].u_if.tx_ready;
            tick();
        end
        seq = '0;
        rdy_low = 0;
        bsy = 0;
        for (int unsigned k = 0; k < 10; k++) seq[k] = tr_ser[0][4 * k];
        for (int unsigned i = 0; i < 40; i++) begin
            if (!tr_rdy[0][i]) rdy_low++;
            if (tr_busy[0][i]) bsy++;
        end
        want = {1'b1, b0, 1'b0};
        check_val("frame_bits", seq, want);
        check_val("ready_low_cycles", rdy_low, 39);
        check_val("ready_last_stop", tr_rdy[0][39], 1'b1);
        check_val("busy_cycles", bsy, 40);
        check_val("busy_after_frame", tr_busy[0][40], 1'b0);
    endtask

    initial begin
        logic        trace [60];
        logic [7:0]  got_byte;
        int unsigned bsy;
        logic        stop_ok;

        set_valid(1'b0);
        set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) tick();
        check_val("reset_serial", g_dut[0].serial_tx, 1'b1);
        check_val("reset_ready", g_dut[0].u_if.tx_ready, 1'b0);
        #2;
        reset_n = 1'b1;
        #1;
        check_val("ready_before_edge", g_dut[0].u_if.tx_ready, 1'b0);
        tick();
        check_val("ready_first_edge", g_dut[0].u_if.tx_ready, 1'b1);

        // Single frames: 8N1 0xA5, even parity 0x07, 7-bit two-stop 0xFF, odd parity 0x07.
        set_bytes(8'hA5, 8'h07, 8'hFF, 8'h07);
        set_valid(1'b1);
        tick();
        set_valid(1'b0);
        capture(8'hA5);
        check_val("even_parity_bit", tr_ser[1][36], 1'b1);
        check_val("even_busy_last", tr_busy[1][43], 1'b1);
        check_val("even_busy_after", tr_busy[1][44], 1'b0);
        check_val("odd_parity_bit", tr_ser[3][12], 1'b0);
        check_val("odd_busy_after", tr_busy[3][16], 1'b0);
        stop_ok = 1'b1;
        for (int unsigned i = 32; i < 40; i++) stop_ok &= tr_ser[2][i];
        check_val("two_stop_high", stop_ok, 1'b1);
        check_val("two_stop_busy_last", tr_busy[2][39], 1'b1);
        check_val("two_stop_busy_after", tr_busy[2][40], 1'b0);
        repeat (10) tick();

        // Back-to-back: valid held high, 0x00 then 0xFF.
        set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
        set_valid(1'b1);
        tick();
        set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        bsy = 0;
        for (int unsigned i = 0; i <= 80; i++) begin
            if (i == 40) set_valid(1'b0);
            if (i < 80 && g_dut[0].busy) bsy++;
            if (i == 39) check_val("b2b_last_stop", g_dut[0].serial_tx, 1'b1);
            if (i == 40) check_val("b2b_next_start", g_dut[0].serial_tx, 1'b0);
            if (i == 80) check_val("b2b_idle_after", g_dut[0].busy, 1'b0);
            tick();
        end
        check_val("b2b_busy_cycles", bsy, 80);
        repeat (20) tick();

        // Byte changes and valid pulses while busy must not disturb the frame.
        set_bytes(8'h5A, 8'h5A, 8'h5A, 8'h5A);
        set_valid(1'b1);
        tick();
        for (int unsigned i = 0; i < 60; i++) begin
            trace[i] = g_dut[0].serial_tx;
            if (i < 36 && (i % 6) == 2) begin
                set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                set_valid(1'b1);
            end else begin
                set_valid(1'b0);
            end
            tick();
        end
        got_byte = '0;
        for (int unsigned k = 0; k < 8; k++) got_byte[k] = trace[4 + 4 * k];
        check_val("busy_ignore_data", got_byte, 8'h5A);
        stop_ok = 1'b1;
        for (int unsigned i = 36; i < 60; i++) stop_ok &= trace[i];
        check_val("busy_no_extra_frame", stop_ok, 1'b1);
        repeat (20) tick();

        // Reset in the middle of data bit 3, between clock edges.
        set_bytes(8'h96, 8'h96, 8'h96, 8'h96);
        set_valid(1'b1);
        tick();
        set_valid(1'b0);
        repeat (17) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_val("midrst_serial0", g_dut[0].serial_tx, 1'b1);
        check_val("midrst_ready0", g_dut[0].u_if.tx_ready, 1'b0);
        check_val("midrst_busy0", g_dut[0].busy, 1'b0);
        check_val("midrst_serial2", g_dut[2].serial_tx, 1'b1);
        repeat (3) tick();
        #2;
        reset_n = 1'b1;
        #1;
        check_val("rel_ready_before_edge", g_dut[0].u_if.tx_ready, 1'b0);
        tick();
        check_val("rel_ready_first_edge", g_dut[0].u_if.tx_ready, 1'b1);
        check_val("rel_no_resume", g_dut[0].serial_tx, 1'b1);
        set_bytes(8'h3C, 8'h3C, 8'h3C, 8'h3C);
        set_valid(1'b1);
        tick();
        set_valid(1'b0);
        capture(8'h3C);
        repeat (10) tick();

        // Randomized traffic, checked cycle by cycle against the line models.
        for (int unsigned n = 0; n < 500; n++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                stim_byte[i]  = 8'($urandom);
                stim_valid[i] = ($urandom_range(0, 3) == 0);
            end
            tick();
        end
        set_valid(1'b0);
        repeat (60) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
